// File: rtl/fifo_ram_pkg.sv
// ============================================================================
// Module   : fifo_ram_pkg
// Purpose  : Shared constants and grant encoding for the RAM-backed FIFO.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_ram_pkg;

    localparam int c_dw_default    = 8;
    localparam int c_aw_default    = 10;
    localparam int c_depth_default = 1 << c_aw_default;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } grant_t;

endpackage

`default_nettype wire

// File: rtl/fifo_ram_arb.sv
// ============================================================================
// Module   : fifo_ram_arb
// Purpose  : Two-way round-robin arbiter sharing one RAM port between writes and reads.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_ram_arb
    import fifo_ram_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_wr_req,
    input  logic   i_rd_req,
    output logic   o_wr_gnt,
    output logic   o_rd_gnt,
    output grant_t o_last_grant
);

    grant_t r_last_grant;

    // On a conflict the side that did not win last time goes next.
    always_comb begin
        o_wr_gnt = 1'b0;
        o_rd_gnt = 1'b0;
        if (i_wr_req && i_rd_req) begin
            if (r_last_grant == READ) begin
                o_wr_gnt = 1'b1;
            end else begin
                o_rd_gnt = 1'b1;
            end
        end else begin
            o_wr_gnt = i_wr_req;
            o_rd_gnt = i_rd_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= READ;
        end else if (o_wr_gnt) begin
            r_last_grant <= WRITE;
        end else if (o_rd_gnt) begin
            r_last_grant <= READ;
        end
    end

    assign o_last_grant = r_last_grant;

endmodule

`default_nettype wire

// File: rtl/fifo_ram_ctrl.sv
// ============================================================================
// Module   : fifo_ram_ctrl
// Purpose  : FIFO controller over an external single-port RAM with a
//            registered output stage. FIFO_RAM_CTRL_BYPASS_EN enables the
//            empty-FIFO bypass straight into the output register.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_ram_ctrl
    import fifo_ram_pkg::*;
#(
    parameter int DW = c_dw_default,
    parameter int AW = c_aw_default
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [AW:0]   level
);

    localparam logic [AW:0] c_depth = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_ram_cnt;
    logic          r_inflight;
    logic          r_out_valid;
    logic [DW-1:0] r_out_data;

    logic          w_wr_elig;
    logic          w_rd_elig;
    logic          w_wr_req;
    logic          w_wr_gnt;
    logic          w_rd_gnt;
    logic          w_bypass;
    logic [AW:0]   w_level;
    grant_t        w_last_grant;

    assign w_level = r_ram_cnt + {{AW{1'b0}}, r_inflight} + {{AW{1'b0}}, r_out_valid};

    assign w_wr_elig = !rst && (r_ram_cnt < c_depth);
    assign w_rd_elig = (r_ram_cnt != '0) && !r_inflight && (!r_out_valid || out_ready);

`ifdef FIFO_RAM_CTRL_BYPASS_EN
    assign w_bypass = !rst && in_valid && (w_level == '0);
`else
    assign w_bypass = 1'b0;
`endif

    // in_valid gates the actual write request so an idle push side never blocks reads.
    assign w_wr_req = w_wr_elig && in_valid && !w_bypass;

    fifo_ram_arb u_arb (
        .clk          (clk),
        .rst          (rst),
        .i_wr_req     (w_wr_req),
        .i_rd_req     (w_rd_elig),
        .o_wr_gnt     (w_wr_gnt),
        .o_rd_gnt     (w_rd_gnt),
        .o_last_grant (w_last_grant)
    );

    assign in_ready  = w_wr_elig && !(w_rd_elig && (w_last_grant == WRITE));
    assign ram_we    = w_wr_gnt;
    assign ram_addr  = w_wr_gnt ? r_wr_ptr : r_rd_ptr;
    assign ram_wdata = in_data;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign level     = w_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_ram_cnt   <= '0;
            r_inflight  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_wr_gnt) begin
                r_wr_ptr  <= r_wr_ptr + 1'b1;
                r_ram_cnt <= r_ram_cnt + 1'b1;
            end else if (w_rd_gnt) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_ram_cnt <= r_ram_cnt - 1'b1;
            end

            r_inflight <= w_rd_gnt;

            // A read is only issued once the output register is free or draining.
            if (r_inflight) begin
                r_out_valid <= 1'b1;
                r_out_data  <= ram_rdata;
            end else if (w_bypass) begin
                r_out_valid <= 1'b1;
                r_out_data  <= in_data;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_ram_ctrl.sv
// ============================================================================
// Module   : tb_fifo_ram_ctrl
// Purpose  : Directed self-checking bench for fifo_ram_ctrl with a registered RAM model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_ram_ctrl;

    localparam int DW = 8;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [AW:0]   level;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mem [0:1023];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else        ram_rdata     <= mem[ram_addr];
    end

    fifo_ram_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .level     (level)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0)  begin n_errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (ram_we !== 1'b0)    begin n_errors++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
        n_checks++; if (level !== 11'd0)    begin n_errors++; $display("FAIL reset_level: got %0d want 0", level); end
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (ram_we !== 1'b0)    begin n_errors++; $display("FAIL reset_hold_ram_we: got %b want 0", ram_we); end
        n_checks++; if (level !== 11'd0)    begin n_errors++; $display("FAIL reset_hold_level: got %0d want 0", level); end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk); in_valid = 1'b1; in_data = 8'h56; out_ready = 1'b1; #1;
        n_checks++; if (ram_we !== 1'b1)     begin n_errors++; $display("FAIL single_c0_we: got %b want 1", ram_we); end
        n_checks++; if (ram_addr !== 10'd0)  begin n_errors++; $display("FAIL single_c0_addr: got %0d want 0", ram_addr); end
        n_checks++; if (ram_wdata !== 8'h56) begin n_errors++; $display("FAIL single_c0_wdata: got %h want 56", ram_wdata); end
        @(negedge clk); in_valid = 1'b0; #1;
        n_checks++; if (ram_we !== 1'b0)     begin n_errors++; $display("FAIL single_c1_we: got %b want 0", ram_we); end
        n_checks++; if (ram_addr !== 10'd0)  begin n_errors++; $display("FAIL single_c1_addr: got %0d want 0", ram_addr); end
        @(negedge clk); #1;
        n_checks++; if (out_valid !== 1'b0)  begin n_errors++; $display("FAIL single_c2_valid: got %b want 0", out_valid); end
        n_checks++; if (level !== 11'd1)     begin n_errors++; $display("FAIL single_c2_level: got %0d want 1", level); end
        @(negedge clk); #1;
        n_checks++; if (out_valid !== 1'b1)  begin n_errors++; $display("FAIL single_c3_valid: got %b want 1", out_valid); end
        n_checks++; if (out_data !== 8'h56)  begin n_errors++; $display("FAIL single_c3_data: got %h want 56", out_data); end
        @(negedge clk); #1;
        n_checks++; if (out_valid !== 1'b0)  begin n_errors++; $display("FAIL single_c4_valid: got %b want 0", out_valid); end
        n_checks++; if (level !== 11'd0)     begin n_errors++; $display("FAIL single_c4_level: got %0d want 0", level); end
    endtask

    task automatic test_bypass();
        do_reset();
        @(negedge clk); in_valid = 1'b1; in_data = 8'h36; out_ready = 1'b0; #1;
        n_checks++; if (in_ready !== 1'b1)  begin n_errors++; $display("FAIL bypass_in_ready: got %b want 1", in_ready); end
        n_checks++; if (ram_we !== 1'b0)    begin n_errors++; $display("FAIL bypass_c0_we: got %b want 0", ram_we); end
        @(negedge clk); in_valid = 1'b0; #1;
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bypass_valid: got %b want 1", out_valid); end
        n_checks++; if (out_data !== 8'h36) begin n_errors++; $display("FAIL bypass_data: got %h want 36", out_data); end
        n_checks++; if (ram_we !== 1'b0)    begin n_errors++; $display("FAIL bypass_c1_we: got %b want 0", ram_we); end
        n_checks++; if (level !== 11'd1)    begin n_errors++; $display("FAIL bypass_level: got %0d want 1", level); end
    endtask

    task automatic test_full();
        int acc = 0;
        do_reset();
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk); in_valid = 1'b1; in_data = 8'(acc); out_ready = 1'b0; #1;
            if (in_ready) acc++;
        end
        n_checks++; if (acc != 1025)          begin n_errors++; $display("FAIL full_accepted: got %0d want 1025", acc); end
        n_checks++; if (level !== 11'd1025)   begin n_errors++; $display("FAIL full_level: got %0d want 1025", level); end
        n_checks++; if (in_ready !== 1'b0)    begin n_errors++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        n_checks++; if (ram_we !== 1'b0)      begin n_errors++; $display("FAIL full_ram_we: got %b want 0", ram_we); end
        n_checks++; if (out_valid !== 1'b1)   begin n_errors++; $display("FAIL full_out_valid: got %b want 1", out_valid); end
        n_checks++; if (out_data !== 8'h00)   begin n_errors++; $display("FAIL full_out_data: got %h want 00", out_data); end
    endtask

    task automatic test_alternate();
        logic [7:0] q[$];
        logic [7:0] nxt = 8'h10;
        logic       exp_we;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); in_valid = 1'b1; in_data = nxt; out_ready = 1'b1; #1;
`ifdef FIFO_RAM_CTRL_BYPASS_EN
            exp_we = (c % 2) == 1;
`else
            exp_we = (c % 2) == 0;
`endif
            n_checks++; if (ram_we !== exp_we) begin n_errors++; $display("FAIL alt_grant c=%0d: got we=%b want %b", c, ram_we, exp_we); end
            if (out_valid && out_ready) begin
                n_checks++;
                if (q.size() == 0 || out_data !== q[0]) begin n_errors++; $display("FAIL alt_pop c=%0d: got %h want %h", c, out_data, (q.size() != 0) ? q[0] : 8'h00); end
                if (q.size() != 0) void'(q.pop_front());
            end
            if (in_valid && in_ready) begin q.push_back(in_data); nxt++; end
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); in_valid = 1'b0; #1;
            if (out_valid && out_ready) begin
                n_checks++;
                if (q.size() == 0 || out_data !== q[0]) begin n_errors++; $display("FAIL alt_drain c=%0d: got %h want %h", c, out_data, (q.size() != 0) ? q[0] : 8'h00); end
                if (q.size() != 0) void'(q.pop_front());
            end
        end
        n_checks++; if (q.size() != 0)    begin n_errors++; $display("FAIL alt_left: got %0d words left want 0", q.size()); end
        n_checks++; if (level !== 11'd0)  begin n_errors++; $display("FAIL alt_level: got %0d want 0", level); end
    endtask

    task automatic test_wrap();
        int            sent = 0;
        int            rcvd = 0;
        int            cyc = 0;
        logic [AW-1:0] exp_wa = '0;
        bit            wrapped = 0;
        bit            pop;
        bit            prev_pop = 0;
        do_reset();
        while (rcvd < 1030 && cyc < 5000) begin
            @(negedge clk); in_valid = (sent < 1030); in_data = 8'(sent); out_ready = 1'b1; #1;
            if (ram_we) begin
                n_checks++; if (ram_addr !== exp_wa) begin n_errors++; $display("FAIL wrap_addr: got %0d want %0d", ram_addr, exp_wa); end
                if (exp_wa == 10'd1023) wrapped = 1;
                exp_wa++;
            end
            pop = out_valid && out_ready;
            if (pop) begin
                n_checks++; if (out_data !== 8'(rcvd)) begin n_errors++; $display("FAIL wrap_data #%0d: got %h want %h", rcvd, out_data, 8'(rcvd)); end
                n_checks++; if (prev_pop) begin n_errors++; $display("FAIL wrap_rate #%0d: got back-to-back pops want gap", rcvd); end
                rcvd++;
            end
            prev_pop = pop;
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        n_checks++; if (rcvd != 1030)   begin n_errors++; $display("FAIL wrap_count: got %0d want 1030", rcvd); end
        n_checks++; if (!wrapped)       begin n_errors++; $display("FAIL wrap_seen: got 0 want 1"); end
        @(negedge clk); in_valid = 1'b0; #1;
        n_checks++; if (level !== 11'd0) begin n_errors++; $display("FAIL wrap_level: got %0d want 0", level); end
    endtask

    task automatic test_async_reset();
        int acc = 0;
        do_reset();
        for (int c = 0; c < 50 && acc < 5; c++) begin
            @(negedge clk); in_valid = 1'b1; in_data = 8'(8'hC0 + acc); out_ready = 1'b0; #1;
            if (in_ready) acc++;
        end
        @(negedge clk); in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        n_checks++; if (level !== 11'd5) begin n_errors++; $display("FAIL arst_pre_level: got %0d want 5", level); end
        @(negedge clk); in_valid = 1'b1; in_data = 8'h99; #1;
        #1; rst = 1'b1; #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b0)  begin n_errors++; $display("FAIL arst_in_ready: got %b want 0", in_ready); end
        n_checks++; if (ram_we !== 1'b0)    begin n_errors++; $display("FAIL arst_ram_we: got %b want 0", ram_we); end
        n_checks++; if (level !== 11'd0)    begin n_errors++; $display("FAIL arst_level: got %0d want 0", level); end
        @(negedge clk); rst = 1'b0; in_valid = 1'b1; in_data = 8'h77; #1;
`ifdef FIFO_RAM_CTRL_BYPASS_EN
        n_checks++; if (ram_we !== 1'b0)    begin n_errors++; $display("FAIL arst_first_we: got %b want 0", ram_we); end
        @(negedge clk); in_data = 8'h78; #1;
`endif
        n_checks++; if (ram_we !== 1'b1)    begin n_errors++; $display("FAIL arst_push_we: got %b want 1", ram_we); end
        n_checks++; if (ram_addr !== 10'd0) begin n_errors++; $display("FAIL arst_push_addr: got %0d want 0", ram_addr); end
        @(negedge clk); in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
`ifdef FIFO_RAM_CTRL_BYPASS_EN
        test_bypass();
`else
        test_single();
`endif
        test_full();
        test_alternate();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
